branch_resolve_unit: RTL
========================

Name: branch_resolve_unit

Overview:
- Parametrised successor to the ID-stage branch comparator.
- Evaluates all MIPS branch conditions on forwarded operands and registers the taken/flag results.
- Keeps a 2-bit-saturating-counter branch history table (BHT), looked up combinationally by IF, and updated at resolution.
- Flags mispredictions for the pipeline flush logic and keeps saturating branch/mispredict statistics counters.

Parameters:
WIDTH, 32, operand width in bits
IDX_W, 6, BHT index width; BHT depth = 2**IDX_W entries
CNT_W, 16, width of each statistics counter

Ports:
clk  in  1  system clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  ID stage stalled; freezes all state
valid_i  in  1  ID-stage instruction is a branch to resolve this cycle
cond_i  in  3  condition select: 0 BEQ, 1 BNE, 2 BLEZ, 3 BGTZ, 4 BLTZ, 5 BGEZ, 6-7 illegal
rs_i  in  WIDTH  forwarded rs operand, signed
rt_i  in  WIDTH  forwarded rt operand (used by BEQ/BNE only)
res_idx_i  in  IDX_W  BHT index of the branch being resolved (PC[IDX_W+1:2])
pred_i  in  1  prediction made in IF for this branch, carried down the pipe
lookup_idx_i  in  IDX_W  IF-stage BHT index
lookup_taken_o  out  1  combinational prediction: MSB of BHT[lookup_idx_i]
valid_o  out  1  registered: a resolution result is present
taken_o  out  1  registered branch outcome
mispredict_o  out  1  registered: valid and taken != pred
illegal_o  out  1  registered: valid with cond_i 6-7
eq_o, ne_o, zero_o, gtz_o, ltz_o  out  1 each  registered compare flags of rs_i (and rt_i for eq/ne)
branch_cnt_o  out  CNT_W  resolved-branch count
mispred_cnt_o  out  CNT_W  misprediction count

Behaviour:
- Reset: all registered outputs 0, both stats counters 0, every BHT entry 2'b01 (weakly not-taken).
- Reset wins over stall and valid_i. Reset mid-operation discards any in-flight result.
- Flags (signed), evaluated combinationally:
  - zero = rs==0
  - ltz = rs[WIDTH-1]
  - gtz = !rs[WIDTH-1] && |rs[WIDTH-2:0]
  - eq = rs==rt; ne = !eq
- Taken by condition:
  - BEQ = eq; BNE = ne
  - BLEZ = zero|ltz; BGTZ = gtz
  - BLTZ = ltz; BGEZ = !ltz
  - Illegal codes: taken = 0, illegal_o = 1.
- Latency: 1 cycle. Outputs reflect the inputs of the previous enabled edge.
- Cycle with stall=0, valid_i=0: valid_o, taken_o, mispredict_o, illegal_o go to 0. Flags still update.
- Cycle with stall=1: all outputs, the BHT and the stats counters hold their values.
- BHT update on an enabled edge with valid_i=1 and a legal cond:
  - taken: counter +1, saturating at 11
  - not taken: counter -1, saturating at 00
  - Illegal cond: no BHT update. branch_cnt still increments; mispred_cnt increments if pred_i != 0.
- Stats counters saturate at 2**CNT_W-1 and never wrap.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update value (read-before-write). There is no bypass.
- lookup_taken_o is purely combinational from the BHT state and lookup_idx_i.

Decomposition:
- Package branch_pkg: cond codes (COND_BEQ..COND_BGEZ), BHT state constants (SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11), BHT_RESET=WNT.
- Sub-module branch_cond_eval: combinational flag and taken evaluation, parametrised on WIDTH.
- BHT and stats counters stay in the top module.

Test Plan:
- Reset, then lookup indices 0..63 -> every lookup_taken_o=0; all outputs and both counters 0.
- BEQ rs=5 rt=5 pred=0 idx=3 -> next cycle valid_o=1, taken_o=1, eq_o=1, mispredict_o=1, mispred_cnt_o=1. Lookup idx 3 then -> 1 (counter 10).
- BGTZ rs=0x80000000 -> taken_o=0, ltz_o=1. BLEZ rs=0 -> taken_o=1, zero_o=1. BGEZ rs=0 -> taken_o=1. BLTZ rs=0x00000001 -> taken_o=0, gtz_o=1.
- Four taken BEQs at idx 7, then one not-taken -> counter 11 then 10; lookup_taken_o stays 1. Same-cycle lookup idx 7 during the update -> returns the pre-update value.
- stall=1 for 3 cycles with valid_i=1, BNE rs=1 rt=2 -> outputs, BHT and counters unchanged; the update happens on the first cycle with stall=0.
- CNT_W=4: 20 branches with pred_i wrong each time -> branch_cnt_o=15, mispred_cnt_o=15. Then a rst pulse -> next cycle counters 0 and all BHT entries predict not-taken.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared encodings for the branch resolve unit: condition codes, BHT
// counter states and the 2-bit saturating counter step.
package branch_pkg;

    typedef enum logic [2:0] {
        COND_BEQ  = 3'd0,
        COND_BNE  = 3'd1,
        COND_BLEZ = 3'd2,
        COND_BGTZ = 3'd3,
        COND_BLTZ = 3'd4,
        COND_BGEZ = 3'd5
    } cond_e;

    localparam logic [1:0] SNT       = 2'b00;
    localparam logic [1:0] WNT       = 2'b01;
    localparam logic [1:0] WT        = 2'b10;
    localparam logic [1:0] ST        = 2'b11;
    localparam logic [1:0] BHT_RESET = WNT;

    // Next counter state after a resolved branch; saturates at SNT and ST.
    function automatic logic [1:0] bht_next(input logic [1:0] state, input logic taken);
        logic [1:0] nxt;
        case (state)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            default: nxt = taken ? ST  : WT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational compare flags and branch-taken evaluation on forwarded operands.
module branch_cond_eval
    import branch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       cond_i,
    input  logic [WIDTH-1:0] rs_i,
    input  logic [WIDTH-1:0] rt_i,
    output logic             eq_o,
    output logic             ne_o,
    output logic             zero_o,
    output logic             gtz_o,
    output logic             ltz_o,
    output logic             taken_o,
    output logic             illegal_o
);

    assign zero_o = (rs_i == '0);
    assign ltz_o  = rs_i[WIDTH-1];
    assign gtz_o  = !rs_i[WIDTH-1] && (|rs_i[WIDTH-2:0]);
    assign eq_o   = (rs_i == rt_i);
    assign ne_o   = !eq_o;

    // Select the outcome for the requested condition; codes 6-7 are never taken.
    always_comb begin
        taken_o   = 1'b0;
        illegal_o = 1'b0;
        case (cond_i)
            COND_BEQ:  taken_o = eq_o;
            COND_BNE:  taken_o = ne_o;
            COND_BLEZ: taken_o = zero_o | ltz_o;
            COND_BGTZ: taken_o = gtz_o;
            COND_BLTZ: taken_o = ltz_o;
            COND_BGEZ: taken_o = !ltz_o;
            default:   illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolution: registered outcome/flags, 2-bit BHT with
// read-before-write lookup, and saturating branch/mispredict statistics.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IDX_W = 6,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             valid_i,
    input  logic [2:0]       cond_i,
    input  logic [WIDTH-1:0] rs_i,
    input  logic [WIDTH-1:0] rt_i,
    input  logic [IDX_W-1:0] res_idx_i,
    input  logic             pred_i,
    input  logic [IDX_W-1:0] lookup_idx_i,
    output logic             lookup_taken_o,
    output logic             valid_o,
    output logic             taken_o,
    output logic             mispredict_o,
    output logic             illegal_o,
    output logic             eq_o,
    output logic             ne_o,
    output logic             zero_o,
    output logic             gtz_o,
    output logic             ltz_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    localparam int         DEPTH   = 2 ** IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0] bht [DEPTH];

    logic flag_eq, flag_ne, flag_zero, flag_gtz, flag_ltz;
    logic cond_taken, cond_illegal, wrong_pred, enable;

    branch_cond_eval #(.WIDTH(WIDTH)) u_cond_eval (
        .cond_i    (cond_i),
        .rs_i      (rs_i),
        .rt_i      (rt_i),
        .eq_o      (flag_eq),
        .ne_o      (flag_ne),
        .zero_o    (flag_zero),
        .gtz_o     (flag_gtz),
        .ltz_o     (flag_ltz),
        .taken_o   (cond_taken),
        .illegal_o (cond_illegal)
    );

    assign enable         = !stall;
    assign wrong_pred     = (cond_taken != pred_i);
    assign lookup_taken_o = bht[lookup_idx_i][1];

    // Result, flag and statistics registers; flags track rs/rt even without a branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o       <= 1'b0;
            taken_o       <= 1'b0;
            mispredict_o  <= 1'b0;
            illegal_o     <= 1'b0;
            eq_o          <= 1'b0;
            ne_o          <= 1'b0;
            zero_o        <= 1'b0;
            gtz_o         <= 1'b0;
            ltz_o         <= 1'b0;
            branch_cnt_o  <= '0;
            mispred_cnt_o <= '0;
        end else if (enable) begin
            valid_o      <= valid_i;
            taken_o      <= valid_i & cond_taken;
            mispredict_o <= valid_i & wrong_pred;
            illegal_o    <= valid_i & cond_illegal;
            eq_o         <= flag_eq;
            ne_o         <= flag_ne;
            zero_o       <= flag_zero;
            gtz_o        <= flag_gtz;
            ltz_o        <= flag_ltz;
            if (valid_i) begin
                if (branch_cnt_o != CNT_MAX)
                    branch_cnt_o <= branch_cnt_o + CNT_W'(1);
                if (wrong_pred && (mispred_cnt_o != CNT_MAX))
                    mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
            end
        end
    end

    // BHT training; illegal conditions leave the table untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                bht[i] <= BHT_RESET;
        end else if (enable && valid_i && !cond_illegal) begin
            bht[res_idx_i] <= bht_next(bht[res_idx_i], cond_taken);
        end
    end

endmodule
